// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pc_sequencer_pkg                                           |
// | Brief   : Shared constants and state encoding for the PC sequencer.  |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package pc_sequencer_pkg;

  // PC width and the fixed addresses/increment used by the sequencer
  localparam int                ADDR_W    = 13;
  localparam logic [ADDR_W-1:0] PC_INC    = 13'd4;
  localparam logic [ADDR_W-1:0] RESET_VEC = 13'h0000;
  localparam logic [ADDR_W-1:0] EXC_VEC   = 13'h0100;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

endpackage : pc_sequencer_pkg
`default_nettype wire

// File: rtl/pc_sequencer_redirect_latch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pc_sequencer_redirect_latch                                |
// | Brief   : Holds one redirect target that arrived while a fetch was   |
// |           still outstanding. A newer redirect overwrites the old one.|
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module pc_sequencer_redirect_latch
  import pc_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              set_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] target_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] target_o
);

  logic              valid_q;
  logic              valid_d;
  logic [ADDR_W-1:0] target_q;
  logic [ADDR_W-1:0] target_d;

  // Next-state: clear wins, otherwise a new redirect overwrites any held one
  always_comb begin
    valid_d  = valid_q;
    target_d = target_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (set_i) begin
      valid_d  = 1'b1;
      target_d = target_i;
    end
  end

  // Pending register; reset drops any latched redirect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      target_q <= RESET_VEC;
    end else begin
      valid_q  <= valid_d;
      target_q <= target_d;
    end
  end

  assign valid_o  = valid_q;
  assign target_o = target_q;

endmodule : pc_sequencer_redirect_latch
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pc_sequencer                                               |
// | Brief   : Drives pc_next for the PC register every cycle: fetch      |
// |           handshake, hazard hold/refetch, branch/jump redirects      |
// |           (including mid-fetch), exceptions and halt.                |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module pc_sequencer
  import pc_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_cur_i,
  input  logic              imem_ack_i,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  input  logic              exc_i,
  input  logic              halt_i,
  output logic [ADDR_W-1:0] pc_next_o,
  output logic              imem_req_o,
  output logic              fetch_valid_o,
  output logic              halted_o,
  output logic              redir_pend_o
);

  state_e            state_q;
  state_e            state_d;

  logic              w_redir_now;
  logic [ADDR_W-1:0] w_redir_tgt;
  logic              w_pend_set;
  logic              w_pend_clr;
  logic              w_pend_valid;
  logic [ADDR_W-1:0] w_pend_tgt;

  // A jump decoded in the same cycle as a taken branch takes precedence
  assign w_redir_now = jump_i | branch_taken_i;
  assign w_redir_tgt = jump_i ? jump_target_i : branch_target_i;

  pc_sequencer_redirect_latch u_redirect_latch (
    .clk      (clk),
    .reset    (reset),
    .set_i    (w_pend_set),
    .clr_i    (w_pend_clr),
    .target_i (w_redir_tgt),
    .valid_o  (w_pend_valid),
    .target_o (w_pend_tgt)
  );

  // State register; reset aborts any fetch in flight and returns to BOOT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-PC selection; holding the PC means feeding pc_cur back
  always_comb begin
    state_d       = state_q;
    pc_next_o     = pc_cur_i;
    fetch_valid_o = 1'b0;
    imem_req_o    = (state_q == ST_FETCH);
    halted_o      = (state_q == ST_HALTED);
    w_pend_set    = 1'b0;
    w_pend_clr    = 1'b0;

    if (state_q == ST_BOOT) begin
      pc_next_o = RESET_VEC;
      state_d   = ST_FETCH;
    end else if (exc_i) begin
      // Exception also wakes a halted core
      pc_next_o  = EXC_VEC;
      w_pend_clr = 1'b1;
      state_d    = ST_FETCH;
    end else if (halt_i) begin
      w_pend_clr = 1'b1;
      state_d    = ST_HALTED;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (!imem_ack_i) begin
            // Fetch still outstanding: remember the redirect until data returns
            w_pend_set = w_redir_now;
          end else if (w_redir_now) begin
            pc_next_o  = w_redir_tgt;
            w_pend_clr = 1'b1;
          end else if (w_pend_valid) begin
            pc_next_o  = w_pend_tgt;
            w_pend_clr = 1'b1;
          end else if (stall_i) begin
            state_d = ST_HOLD;
          end else begin
            fetch_valid_o = 1'b1;
            pc_next_o     = pc_cur_i + PC_INC;
          end
        end
        ST_HOLD: begin
          if (w_redir_now) begin
            pc_next_o  = w_redir_tgt;
            w_pend_clr = 1'b1;
            state_d    = ST_FETCH;
          end else if (!stall_i) begin
            // Refetch the same address; the held instruction was not consumed
            state_d = ST_FETCH;
          end
        end
        default: begin
          // HALTED: only reset or an exception leaves this state
          state_d = ST_HALTED;
        end
      endcase
    end
  end

  assign redir_pend_o = w_pend_valid;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_pc_sequencer                                            |
// | Brief   : Directed self-checking bench for pc_sequencer with a       |
// |           behavioural PC register closing the loop.                  |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic [12:0] pc_q;
  logic        ack;
  logic        stall;
  logic        br;
  logic [12:0] br_tgt;
  logic        jmp;
  logic [12:0] jmp_tgt;
  logic        exc;
  logic        halt;
  logic [12:0] pc_next;
  logic        imem_req;
  logic        fetch_valid;
  logic        halted;
  logic        redir_pend;

  int n_tests;
  int n_fail;

  pc_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .pc_cur_i        (pc_q),
    .imem_ack_i      (ack),
    .stall_i         (stall),
    .branch_taken_i  (br),
    .branch_target_i (br_tgt),
    .jump_i          (jmp),
    .jump_target_i   (jmp_tgt),
    .exc_i           (exc),
    .halt_i          (halt),
    .pc_next_o       (pc_next),
    .imem_req_o      (imem_req),
    .fetch_valid_o   (fetch_valid),
    .halted_o        (halted),
    .redir_pend_o    (redir_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register model: loads pc_next every rising edge
  initial pc_q = 13'h0000;
  always @(posedge clk) pc_q <= pc_next;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wait to the falling edge, where combinational outputs have settled
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic a, input logic s, input logic b, input logic [12:0] bt,
                       input logic j, input logic [12:0] jt, input logic e, input logic h);
    ack = a; stall = s; br = b; br_tgt = bt; jmp = j; jmp_tgt = jt; exc = e; halt = h;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    drive(1, 0, 0, 13'h0, 0, 13'h0, 0, 0);

    // Reset values
    #2;
    check("rst_pc_next", pc_next, 13'h0000);
    check("rst_imem_req", imem_req, 0);
    check("rst_fetch_valid", fetch_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_redir_pend", redir_pend, 0);
    cyc(); cyc();
    reset = 1'b0;

    // BOOT: one cycle, pc_next=RESET_VEC, no request
    mid();
    check("boot_pc_next", pc_next, 13'h0000);
    check("boot_imem_req", imem_req, 0);
    cyc();

    // Sequential fetch 0x0000, 0x0004, 0x0008
    mid();
    check("seq0_pc", pc_q, 13'h0000);
    check("seq0_fv", fetch_valid, 1);
    check("seq0_next", pc_next, 13'h0004);
    check("seq0_req", imem_req, 1);
    cyc(); mid();
    check("seq1_fv", fetch_valid, 1);
    check("seq1_next", pc_next, 13'h0008);
    cyc(); mid();
    check("seq2_fv", fetch_valid, 1);
    check("seq2_next", pc_next, 13'h000C);
    cyc();

    // Jump to 0x0010 then two wait states
    drive(1, 0, 0, 13'h0, 1, 13'h0010, 0, 0);
    mid();
    check("jmp10_next", pc_next, 13'h0010);
    check("jmp10_fv", fetch_valid, 0);
    cyc();
    drive(0, 0, 0, 13'h0, 0, 13'h0, 0, 0);
    mid();
    check("wait1_next", pc_next, 13'h0010);
    check("wait1_fv", fetch_valid, 0);
    check("wait1_req", imem_req, 1);
    cyc(); mid();
    check("wait2_next", pc_next, 13'h0010);
    check("wait2_fv", fetch_valid, 0);
    cyc();
    ack = 1'b1;
    mid();
    check("wait_ack_next", pc_next, 13'h0014);
    check("wait_ack_fv", fetch_valid, 1);
    cyc();

    // Stall / refetch at 0x0020
    drive(1, 0, 0, 13'h0, 1, 13'h0020, 0, 0);
    cyc();
    drive(1, 1, 0, 13'h0, 0, 13'h0, 0, 0);
    mid();
    check("stall_pc", pc_q, 13'h0020);
    check("stall_next", pc_next, 13'h0020);
    check("stall_fv", fetch_valid, 0);
    cyc(); mid();
    check("hold_next", pc_next, 13'h0020);
    check("hold_req", imem_req, 0);
    check("hold_fv", fetch_valid, 0);
    cyc();
    stall = 1'b0;
    mid();
    check("hold_rel_next", pc_next, 13'h0020);
    check("hold_rel_req", imem_req, 0);
    cyc(); mid();
    check("refetch_req", imem_req, 1);
    check("refetch_fv", fetch_valid, 1);
    check("refetch_next", pc_next, 13'h0024);
    cyc();

    // Mid-fetch redirect: branch then newer jump while ack is low
    drive(1, 0, 0, 13'h0, 1, 13'h0040, 0, 0);
    cyc();
    drive(0, 0, 1, 13'h0080, 0, 13'h0, 0, 0);
    mid();
    check("mf_br_next", pc_next, 13'h0040);
    check("mf_br_pend", redir_pend, 0);
    cyc();
    drive(0, 0, 0, 13'h0, 1, 13'h0100, 0, 0);
    mid();
    check("mf_jmp_pend", redir_pend, 1);
    check("mf_jmp_next", pc_next, 13'h0040);
    cyc();
    drive(0, 0, 0, 13'h0, 0, 13'h0, 0, 0);
    mid();
    check("mf_idle_pend", redir_pend, 1);
    cyc();
    ack = 1'b1;
    mid();
    check("mf_ack_next", pc_next, 13'h0100);
    check("mf_ack_fv", fetch_valid, 0);
    cyc(); mid();
    check("mf_after_pend", redir_pend, 0);
    check("mf_after_next", pc_next, 13'h0104);
    cyc();

    // Halt at 0x0030, hold for 3 cycles, then wake with exception
    drive(1, 0, 0, 13'h0, 1, 13'h0030, 0, 0);
    cyc();
    drive(0, 0, 0, 13'h0, 0, 13'h0, 0, 1);
    mid();
    check("halt_next", pc_next, 13'h0030);
    check("halt_moore", halted, 0);
    cyc();
    halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("halted_flag", halted, 1);
      check("halted_next", pc_next, 13'h0030);
      check("halted_req", imem_req, 0);
      cyc();
    end
    exc = 1'b1;
    mid();
    check("exc_wake_next", pc_next, 13'h0100);
    check("exc_wake_fv", fetch_valid, 0);
    cyc();
    drive(1, 0, 0, 13'h0, 0, 13'h0, 0, 0);
    mid();
    check("exc_fetch_halted", halted, 0);
    check("exc_fetch_req", imem_req, 1);
    check("exc_fetch_next", pc_next, 13'h0104);
    cyc();

    // Exception beats a same-cycle jump with ack
    drive(1, 0, 0, 13'h0, 1, 13'h0200, 1, 0);
    mid();
    check("exc_prio_next", pc_next, 13'h0100);
    check("exc_prio_fv", fetch_valid, 0);
    cyc();

    // Same-cycle jump beats branch
    drive(1, 0, 1, 13'h0300, 1, 13'h0400, 0, 0);
    mid();
    check("jmp_over_br", pc_next, 13'h0400);
    cyc();

    // Wrap 0x1FFC + 4 -> 0x0000
    drive(1, 0, 0, 13'h0, 1, 13'h1FFC, 0, 0);
    cyc();
    drive(1, 0, 0, 13'h0, 0, 13'h0, 0, 0);
    mid();
    check("wrap_next", pc_next, 13'h0000);
    check("wrap_fv", fetch_valid, 1);
    cyc();

    // Async reset mid-fetch with a pending redirect
    drive(0, 0, 1, 13'h0200, 0, 13'h0, 0, 0);
    cyc();
    drive(0, 0, 0, 13'h0, 0, 13'h0, 0, 0);
    #1;
    check("pre_rst_pend", redir_pend, 1);
    reset = 1'b1;
    #1;
    check("arst_pc_next", pc_next, 13'h0000);
    check("arst_req", imem_req, 0);
    check("arst_fv", fetch_valid, 0);
    check("arst_pend", redir_pend, 0);
    cyc();
    reset = 1'b0;
    ack = 1'b1;
    cyc(); mid();
    check("post_rst_pc", pc_q, 13'h0000);
    check("post_rst_next", pc_next, 13'h0004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_pc_sequencer
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller that sequences the 13-bit program counter register of the MIPS core.
- The PC register loads pc_next on every clk edge, so this block drives pc_next every cycle. Holding the PC means feeding pc_cur back.
- Handles instruction-memory handshake, hazard stall, branch/jump redirects (including ones that arrive mid-fetch), exceptions and halt.
- Sits between the PC register, instruction memory and the decode/hazard logic.

Parameters:
ADDR_W, 13, PC width in bits
PC_INC, 4, sequential increment (byte addressing)
RESET_VEC, 13'h0000, PC value after reset
EXC_VEC, 13'h0100, exception handler address

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
pc_cur  in  ADDR_W  current PC register output
imem_ack  in  1  instruction-memory data valid for address pc_cur this cycle
stall  in  1  hazard unit: downstream cannot accept an instruction
branch_taken  in  1  branch resolved taken
branch_target  in  ADDR_W  branch destination
jump  in  1  jump decoded
jump_target  in  ADDR_W  jump destination
exc  in  1  exception request
halt  in  1  halt instruction decoded
pc_next  out  ADDR_W  next value for PC register
imem_req  out  1  fetch request at pc_cur
fetch_valid  out  1  instruction at pc_cur accepted this cycle
halted  out  1  core halted
redir_pend  out  1  a redirect is latched, awaiting fetch completion

Behaviour:
- **States:** BOOT, FETCH, HOLD, HALTED.
- **Reset (async):** state=BOOT, pending redirect cleared, redir_pend=0.
  - Outputs during reset: pc_next=RESET_VEC, imem_req=0, fetch_valid=0, halted=0.
- **Moore outputs:**
  - imem_req=1 only in FETCH.
  - halted=1 only in HALTED.
- **BOOT:** pc_next=RESET_VEC; next state FETCH (exactly one cycle).
- **Priority in FETCH/HOLD/HALTED:** exc > halt > redirect > normal.
  - exc: pc_next=EXC_VEC, pending cleared, fetch_valid=0, next state FETCH (also wakes HALTED).
  - halt (no exc): pc_next=pc_cur, pending cleared, next state HALTED.
  - HALTED without exc: pc_next=pc_cur, stays HALTED until reset or exc.
- **Redirect this cycle:** jump=1 selects jump_target; else branch_taken=1 selects branch_target. Same-cycle jump beats branch.
- **FETCH, imem_ack=0:**
  - pc_next=pc_cur, fetch_valid=0.
  - A redirect this cycle is latched into the pending register; a newer one overwrites it.
- **FETCH, imem_ack=1:**
  - If a redirect is present this cycle or pending: pc_next=that target (this cycle's redirect wins over pending), fetch_valid=0, pending cleared, stay FETCH.
  - Else if stall=1: pc_next=pc_cur, fetch_valid=0, next state HOLD.
  - Else: fetch_valid=1, pc_next=pc_cur+PC_INC, stay FETCH.
- **HOLD:**
  - imem_req=0, fetch_valid=0.
  - Redirect: pc_next=target, next state FETCH.
  - stall=0: pc_next=pc_cur, next state FETCH (refetch the same address).
  - Otherwise pc_next=pc_cur, stay in HOLD.
- **Arithmetic:** pc_cur+PC_INC is modulo 2^ADDR_W. 13'h1FFC+4 wraps to 13'h0000 with no flag.
- **Timing:** pc_next and fetch_valid are combinational from state, pending register and inputs. Fetch latency is 1 cycle minimum (ack in first FETCH cycle).
- **Memory handshake:** memory samples pc_cur each cycle imem_req=1; abandoning a request (exc/halt) needs no cleanup.
- **Reset mid-fetch:** aborts immediately; pending redirect is lost.

Decomposition:
- Shared package: state encoding enum, ADDR_W, RESET_VEC, EXC_VEC, PC_INC constants.
- One sub-module is natural: redirect_latch (pending valid + target register with overwrite and clear).
- FSM and next-PC mux stay in pc_sequencer.

Test Plan:
- **Reset/boot:** reset 1→0, imem_ack=1 always, no stall → pc_next 0x0000 in BOOT; fetch_valid=1 with PC 0x0000, 0x0004, 0x0008 on successive cycles.
- **Wait states:** imem_ack low 2 cycles at PC 0x0010 → pc_next=0x0010 held for 2 cycles, then 0x0014 with one fetch_valid pulse.
- **Stall/refetch:** stall=1 with ack at PC 0x0020 → HOLD, pc_next=0x0020, fetch_valid=0; release stall → FETCH at 0x0020, then 0x0024.
- **Mid-fetch redirect:** branch_taken at 0x0040 target 0x0080 while ack=0, then jump to 0x0100 before ack → redir_pend=1; on ack pc_next=0x0100, fetch_valid=0, redir_pend=0.
- **Exception and halt:** halt at 0x0030 → HALTED, pc held at 0x0030 for ≥3 cycles; exc → pc_next=0x0100, FETCH, halted=0. Also async reset asserted mid-FETCH → outputs at reset values immediately.
- **Wrap:** PC 0x1FFC with ack, no stall → pc_next=0x0000.
